mem_wb_writeback: RTL and testbench

- Memory-to-writeback pipeline stage. Directly upstream of the 3-port register file; drives its RW/PW/LE write port.
- Registers one retiring instruction per cycle.
- Selects the ALU result or aligned, extended load data, big-endian as in SPARC.
- Suppresses writes to r0 and on misaligned loads.
- Exports forwarding info for the operand-read stage.

---
 rtl/mem_wb_writeback.sv | 136 +++++++++++++
 tb/tb_mem_wb_writeback.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// Memory-to-writeback pipeline stage: load alignment/extension, r0 and misalignment write suppression.
// Optional macro WB_LATE_FWD_EN adds a one-cycle-delayed copy of the write port for late forwarding.
module mem_wb_writeback #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          stall,
   input  logic          flush,
   input  logic [AW-1:0] in_rd,
   input  logic          in_rf_le,
   input  logic          in_load,
   input  logic [1:0]    in_size,
   input  logic          in_signed,
   input  logic [1:0]    in_addr_lo,
   input  logic [DW-1:0] in_alu_out,
   input  logic [DW-1:0] in_mem_data,
   output logic [AW-1:0] RW,
   output logic [DW-1:0] PW,
   output logic          LE,
   output logic          wb_valid,
   output logic          trap_misalign
`ifdef WB_LATE_FWD_EN
   ,
   output logic [AW-1:0] fwd2_rd,
   output logic [DW-1:0] fwd2_data,
   output logic          fwd2_valid
`endif
);

   logic          capture;
   logic          misaligned;
   logic [7:0]    byteLane;
   logic [15:0]   halfLane;
   logic [DW-1:0] loadData;
   logic [DW-1:0] pw_d;
   logic          le_d;

   logic [AW-1:0] rw_q;
   logic [DW-1:0] pw_q;
   logic          le_q;
   logic          valid_q;
   logic          trap_q;

   assign in_ready = ~stall;
   assign capture  = in_valid & ~stall & ~flush;

   // Big-endian lane selection: offset 0 is the most significant byte.
   always_comb begin
      byteLane = in_mem_data[31:24];
      case (in_addr_lo)
         2'd0: byteLane = in_mem_data[31:24];
         2'd1: byteLane = in_mem_data[23:16];
         2'd2: byteLane = in_mem_data[15:8];
         2'd3: byteLane = in_mem_data[7:0];
         default: byteLane = in_mem_data[31:24];
      endcase
      halfLane = in_addr_lo[1] ? in_mem_data[15:0] : in_mem_data[31:16];
   end

   always_comb begin
      loadData = in_mem_data;
      case (in_size)
         2'b00:   loadData = {{(DW-8){in_signed & byteLane[7]}}, byteLane};
         2'b01:   loadData = {{(DW-16){in_signed & halfLane[15]}}, halfLane};
         default: loadData = in_mem_data;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      if (in_load) begin
         if (in_size == 2'b01) begin
            misaligned = in_addr_lo[0];
         end else if (in_size[1]) begin
            misaligned = (in_addr_lo != 2'b00);
         end
      end
      pw_d = in_load ? loadData : in_alu_out;
      le_d = in_rf_le & (in_rd != '0) & ~misaligned;
   end

   // Bubbles clear the flags but leave RW/PW holding their previous values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_q    <= '0;
         pw_q    <= '0;
         le_q    <= 1'b0;
         valid_q <= 1'b0;
         trap_q  <= 1'b0;
      end else if (capture) begin
         rw_q    <= in_rd;
         pw_q    <= pw_d;
         le_q    <= le_d;
         valid_q <= 1'b1;
         trap_q  <= misaligned;
      end else begin
         le_q    <= 1'b0;
         valid_q <= 1'b0;
         trap_q  <= 1'b0;
      end
   end

   assign RW            = rw_q;
   assign PW            = pw_q;
   assign LE            = le_q;
   assign wb_valid      = valid_q;
   assign trap_misalign = trap_q;

`ifdef WB_LATE_FWD_EN
   logic [AW-1:0] fwdRd_q;
   logic [DW-1:0] fwdData_q;
   logic          fwdValid_q;

   // Lets the operand stage bypass a value committed in the cycle just before its read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwdRd_q    <= '0;
         fwdData_q  <= '0;
         fwdValid_q <= 1'b0;
      end else begin
         fwdRd_q    <= rw_q;
         fwdData_q  <= pw_q;
         fwdValid_q <= le_q;
      end
   end

   assign fwd2_rd    = fwdRd_q;
   assign fwd2_data  = fwdData_q;
   assign fwd2_valid = fwdValid_q;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: stimulus pushes expected writebacks, a monitor pops and compares.
// Define WB_LATE_FWD_EN to also check the delayed forwarding outputs.
module tb_mem_wb_writeback;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        le;
      logic        trap;
      logic        dataKnown;
   } wbItem_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic [4:0]  in_rd;
   logic        in_rf_le;
   logic        in_load;
   logic [1:0]  in_size;
   logic        in_signed;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu_out;
   logic [31:0] in_mem_data;
   logic [4:0]  RW;
   logic [31:0] PW;
   logic        LE;
   logic        wb_valid;
   logic        trap_misalign;
`ifdef WB_LATE_FWD_EN
   logic [4:0]  fwd2_rd;
   logic [31:0] fwd2_data;
   logic        fwd2_valid;
`endif

   int total = 0;
   int bad = 0;
   wbItem_t sbq[$];

   mem_wb_writeback #(.DW(32), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .in_rd(in_rd), .in_rf_le(in_rf_le),
      .in_load(in_load), .in_size(in_size), .in_signed(in_signed),
      .in_addr_lo(in_addr_lo), .in_alu_out(in_alu_out), .in_mem_data(in_mem_data),
      .RW(RW), .PW(PW), .LE(LE), .wb_valid(wb_valid), .trap_misalign(trap_misalign)
`ifdef WB_LATE_FWD_EN
      , .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data), .fwd2_valid(fwd2_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load semantics using plain shifts and arithmetic on the big-endian word.
   function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] off);
      longint unsigned w = word;
      longint unsigned v;
      if (size == 2'd0) begin
         v = (w >> (8 * (3 - off))) & 'hFF;
         if (sgn && v >= 128) v = v + 'hFFFFFF00;
      end else if (size == 2'd1) begin
         v = (w >> (8 * (2 - off))) & 'hFFFF;
         if (sgn && v >= 32768) v = v + 'hFFFF0000;
      end else begin
         v = w;
      end
      return v[31:0];
   endfunction

   task automatic applyStimulus(input logic rstn, input logic valid, input logic stl, input logic fl,
                                input logic [4:0] rd, input logic rfle, input logic ld,
                                input logic [1:0] size, input logic sgn, input logic [1:0] off,
                                input logic [31:0] alu, input logic [31:0] mem);
      wbItem_t e;
      bit mis;
      @(negedge clk);
      rst_n = rstn; in_valid = valid; stall = stl; flush = fl;
      in_rd = rd; in_rf_le = rfle; in_load = ld; in_size = size; in_signed = sgn;
      in_addr_lo = off; in_alu_out = alu; in_mem_data = mem;
      mis = ld && ((size == 2'd1 && off[0]) || (size >= 2'd2 && off != 2'd0));
      if (rstn && valid && !stl && !fl) begin
         e.rd = rd;
         e.trap = mis;
         e.le = rfle && (rd != 0) && !mis;
         e.dataKnown = !mis;
         e.data = ld ? loadValue(mem, size, sgn, off) : alu;
         sbq.push_back(e);
      end
      #1;
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, ~stl});
   endtask

   task automatic aluOp(input logic [4:0] rd, input logic [31:0] val);
      applyStimulus(1, 1, 0, 0, rd, 1, 0, 2'd2, 0, 2'd0, val, $urandom);
   endtask

   task automatic loadOp(input logic [4:0] rd, input logic [1:0] size, input logic sgn,
                         input logic [1:0] off, input logic [31:0] mem);
      applyStimulus(1, 1, 0, 0, rd, 1, 1, size, sgn, off, $urandom, mem);
   endtask

   task automatic bubble();
      applyStimulus(1, 0, 0, 0, 5'd9, 1, 0, 2'd2, 0, 2'd0, 32'hDEAD_BEEF, 32'h0);
   endtask

   // Monitor: sampled 1 time unit after each rising edge, pops one item per valid WB slot.
   initial begin : monitor
      wbItem_t e;
      logic [4:0]  lastRw = '0;
      logic [31:0] lastPw = '0;
      bit pwKnown = 1;
      bit curLe = 0;
      bit prevLe = 0;
      logic [4:0]  prevRw = '0;
      logic [31:0] prevPw = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            checkOutput("reset_valid", {31'd0, wb_valid}, 32'd0);
            checkOutput("reset_le", {31'd0, LE}, 32'd0);
            checkOutput("reset_trap", {31'd0, trap_misalign}, 32'd0);
            checkOutput("reset_rw", {27'd0, RW}, 32'd0);
            checkOutput("reset_pw", PW, 32'd0);
            sbq.delete();
            lastRw = '0; lastPw = '0; pwKnown = 1; curLe = 0;
         end else if (wb_valid) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_wb actual=valid required=bubble at %0t", $time);
               curLe = LE;
            end else begin
               e = sbq.pop_front();
               checkOutput("rw", {27'd0, RW}, {27'd0, e.rd});
               checkOutput("le", {31'd0, LE}, {31'd0, e.le});
               checkOutput("trap", {31'd0, trap_misalign}, {31'd0, e.trap});
               if (e.dataKnown) checkOutput("pw", PW, e.data);
               lastRw = e.rd; lastPw = e.data; pwKnown = e.dataKnown; curLe = e.le;
            end
         end else begin
            checkOutput("bubble_le", {31'd0, LE}, 32'd0);
            checkOutput("bubble_trap", {31'd0, trap_misalign}, 32'd0);
            checkOutput("bubble_rw_hold", {27'd0, RW}, {27'd0, lastRw});
            if (pwKnown) checkOutput("bubble_pw_hold", PW, lastPw);
            total++;
            if (sbq.size() != 0) begin
               bad++;
               $display("[TB] FAIL missing_wb actual=bubble required=valid at %0t", $time);
               void'(sbq.pop_front());
            end
            curLe = 0;
         end
`ifdef WB_LATE_FWD_EN
         if (!rst_n) begin
            checkOutput("fwd2_valid_reset", {31'd0, fwd2_valid}, 32'd0);
            checkOutput("fwd2_rd_reset", {27'd0, fwd2_rd}, 32'd0);
            checkOutput("fwd2_data_reset", fwd2_data, 32'd0);
         end else begin
            checkOutput("fwd2_valid", {31'd0, fwd2_valid}, {31'd0, prevLe});
            if (prevLe) begin
               checkOutput("fwd2_rd", {27'd0, fwd2_rd}, {27'd0, prevRw});
               checkOutput("fwd2_data", fwd2_data, prevPw);
            end
         end
`endif
         prevLe = curLe; prevRw = lastRw; prevPw = lastPw;
      end
   end

   initial begin : stimulus
      rst_n = 0; in_valid = 1; stall = 0; flush = 0; in_rd = 5'd1; in_rf_le = 1;
      in_load = 0; in_size = 2'd2; in_signed = 0; in_addr_lo = 0;
      in_alu_out = 32'h1111_1111; in_mem_data = 32'h0;
      // Reset held over two edges with a valid instruction presented.
      applyStimulus(0, 1, 0, 0, 5'd1, 1, 0, 2'd2, 0, 2'd0, 32'h1111_1111, 32'h0);
      applyStimulus(0, 1, 0, 0, 5'd1, 1, 0, 2'd2, 0, 2'd0, 32'h1111_1111, 32'h0);
      aluOp(5'd5, 32'h0000_0014);
      loadOp(5'd6, 2'd0, 1, 2'd0, 32'h80FF_7F01);
      loadOp(5'd6, 2'd0, 0, 2'd0, 32'h80FF_7F01);
      loadOp(5'd6, 2'd0, 1, 2'd2, 32'h80FF_7F01);
      loadOp(5'd6, 2'd0, 0, 2'd3, 32'h80FF_7F01);
      loadOp(5'd6, 2'd1, 1, 2'd2, 32'h80FF_7F01);
      loadOp(5'd6, 2'd1, 1, 2'd0, 32'h80FF_7F01);
      loadOp(5'd7, 2'd2, 0, 2'd1, 32'h80FF_7F01);
      bubble();
      aluOp(5'd0, 32'h0000_1234);
      applyStimulus(1, 1, 1, 0, 5'd8, 1, 0, 2'd2, 0, 2'd0, 32'h55, 32'h0);
      applyStimulus(1, 1, 0, 1, 5'd8, 1, 0, 2'd2, 0, 2'd0, 32'h66, 32'h0);
      applyStimulus(1, 1, 1, 1, 5'd8, 1, 0, 2'd2, 0, 2'd0, 32'h77, 32'h0);
      aluOp(5'd3, 32'h0000_000A);
      aluOp(5'd4, 32'h0000_000B);
      bubble();
      aluOp(5'd4, 32'h0000_00C0);
      aluOp(5'd4, 32'h0000_00C1);
      applyStimulus(0, 1, 0, 0, 5'd2, 1, 0, 2'd2, 0, 2'd0, 32'h99, 32'h0);
      aluOp(5'd2, 32'h0000_0042);
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                       5'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                       1'($urandom), 2'($urandom), $urandom, $urandom);
      end
      bubble();
      bubble();
      @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
